// File: rtl/bsg_arb_one_hot_hold.sv
// bsg_arb_one_hot_hold: registered highest-index-wins arbiter that holds a grant for a bounded tenure
module bsg_arb_one_hot_hold #(
    parameter int width_p = 16,
    parameter int max_hold_p = 8,
    localparam int lg_width_lp = $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     reqs_i,
    input  logic                   release_i,
    output logic [width_p-1:0]     grants_o,
    output logic                   grant_v_o,
    output logic [lg_width_lp-1:0] grant_id_o,
    output logic                   expired_o
);
    localparam int cnt_w_lp = (max_hold_p > 0) ? $clog2(max_hold_p + 1) : 1;
    localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_hold_p);
    localparam logic [cnt_w_lp-1:0] one_lp = cnt_w_lp'(1);
    typedef enum logic {IDLE, GRANT} state_e;
    state_e state_q, state_d;
    logic [width_p-1:0] grants_q, grants_d, others;
    logic [lg_width_lp-1:0] id_q, id_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic expired_q, expired_d, v_q;
    logic rel, drop, lim;
    function automatic logic [width_p-1:0] pick(input logic [width_p-1:0] v);
        logic [width_p-1:0] r;
        r = '0;
        for (int i = 0; i < width_p; i++) begin
            if (v[i]) begin
                r = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction
    function automatic logic [lg_width_lp-1:0] id_of(input logic [width_p-1:0] oh);
        logic [lg_width_lp-1:0] r;
        r = '0;
        for (int i = 0; i < width_p; i++) begin
            if (oh[i]) r = lg_width_lp'(i);
        end
        return r;
    endfunction
    assign others = reqs_i & ~grants_q;
    assign rel = release_i;
    assign drop = ~|(reqs_i & grants_q);
    assign lim = (max_hold_p != 0) && (cnt_q == max_cnt_lp);
    // next grant: fresh pick from idle, hold mid-tenure, hand over with no bubble at end of tenure
    always_comb begin
        state_d = state_q;
        grants_d = grants_q;
        cnt_d = cnt_q;
        expired_d = 1'b0;
        if (state_q == IDLE) begin
            if (|reqs_i) begin
                grants_d = pick(reqs_i);
                cnt_d = one_lp;
                state_d = GRANT;
            end
        end else if (rel || drop || lim) begin
            expired_d = lim && !rel && !drop;
            if (|others) begin
                grants_d = pick(others);
                cnt_d = one_lp;
            end else if (expired_d) begin
                cnt_d = one_lp;
            end else begin
                grants_d = '0;
                cnt_d = '0;
                state_d = IDLE;
            end
        end else if ((max_hold_p != 0) && (cnt_q != max_cnt_lp)) begin
            cnt_d = cnt_q + one_lp;
        end
        id_d = id_of(grants_d);
    end
    // register state and every output so nothing reaches grants_o combinationally
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grants_q <= '0;
            id_q <= '0;
            v_q <= 1'b0;
            cnt_q <= '0;
            expired_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grants_q <= grants_d;
            id_q <= id_d;
            v_q <= |grants_d;
            cnt_q <= cnt_d;
            expired_q <= expired_d;
        end
    end
    assign grants_o = grants_q;
    assign grant_v_o = v_q;
    assign grant_id_o = id_q;
    assign expired_o = expired_q;
    grant_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grants_q));
endmodule

// File: tb/tb_bsg_arb_one_hot_hold.sv
// tb_bsg_arb_one_hot_hold: directed scenarios checked against an index/age model and literal expectations
module tb_bsg_arb_one_hot_hold;
    localparam int W = 16;
    localparam int MAXH = 8;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic [W-1:0] reqs_i = '0;
    logic release_i = 1'b0;
    logic [W-1:0] grants_o;
    logic grant_v_o;
    logic [3:0] grant_id_o;
    logic expired_o;
    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;
    int m_holder = -1;
    int m_age = 0;
    bit m_exp = 1'b0;
    bsg_arb_one_hot_hold #(.width_p(W), .max_hold_p(MAXH)) dut (
        .clk_i(clk), .reset_i(reset_i), .reqs_i(reqs_i), .release_i(release_i),
        .grants_o(grants_o), .grant_v_o(grant_v_o), .grant_id_o(grant_id_o), .expired_o(expired_o)
    );
    always #5 clk = ~clk;
    function automatic int highest(input logic [W-1:0] v);
        int r = -1;
        for (int i = 0; i < W; i++) if (v[i]) r = i;
        return r;
    endfunction
    function automatic logic [W-1:0] oh(input int h);
        logic [W-1:0] r = '0;
        if (h >= 0) r[h] = 1'b1;
        return r;
    endfunction
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // model: holder index and tenure age, updated from the arbitration rules on each edge
    always @(posedge clk) begin
        int h, o, age;
        bit ended, byexp;
        logic [W-1:0] rest;
        h = m_holder;
        age = m_age;
        byexp = 1'b0;
        if (reset_i) begin
            h = -1;
            age = 0;
        end else if (h < 0) begin
            h = highest(reqs_i);
            age = (h >= 0) ? 1 : 0;
        end else begin
            ended = release_i || !reqs_i[h] || (MAXH != 0 && age >= MAXH);
            byexp = ended && !release_i && reqs_i[h];
            rest = reqs_i;
            rest[h] = 1'b0;
            o = highest(rest);
            if (!ended) age = age + 1;
            else if (o >= 0) begin h = o; age = 1; end
            else if (byexp) age = 1;
            else begin h = -1; age = 0; end
        end
        m_holder <= h;
        m_age <= age;
        m_exp <= byexp;
        armed <= 1'b1;
    end
    // every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (armed) begin
            check("grants", 32'(grants_o), 32'(oh(m_holder)));
            check("grant_id", 32'(grant_id_o), (m_holder < 0) ? 32'd0 : 32'(m_holder));
            check("grant_v", 32'(grant_v_o), 32'(m_holder >= 0));
            check("expired", 32'(expired_o), 32'(m_exp));
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic lit(input string nm, input logic [W-1:0] g, input logic e);
        check({nm, ".grants"}, 32'(grants_o), 32'(g));
        check({nm, ".id"}, 32'(grant_id_o), (g == 0) ? 32'd0 : 32'(highest(g)));
        check({nm, ".v"}, 32'(grant_v_o), 32'(g != 0));
        check({nm, ".expired"}, 32'(expired_o), 32'(e));
        check({nm, ".model"}, 32'(oh(m_holder)), 32'(g));
    endtask
    initial begin
        reqs_i = 16'hFFFF;
        tick();
        lit("reset_hold", 16'h0000, 1'b0);
        tick();
        lit("reset_hold2", 16'h0000, 1'b0);
        reset_i = 1'b0;
        tick();
        lit("first_grant", 16'h8000, 1'b0);
        reqs_i = 16'h0000;
        tick();
        lit("drop_to_idle", 16'h0000, 1'b0);
        reqs_i = 16'h0124;
        tick();
        lit("priority", 16'h0100, 1'b0);
        reqs_i = 16'h8124;
        tick();
        lit("hold1", 16'h0100, 1'b0);
        tick();
        lit("hold2", 16'h0100, 1'b0);
        release_i = 1'b1;
        tick();
        lit("release_yield", 16'h8000, 1'b0);
        release_i = 1'b0;
        reqs_i = 16'h0003;
        tick();
        lit("yield_after_drop", 16'h0002, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        lit("tenure_last", 16'h0002, 1'b0);
        tick();
        lit("expiry_yield", 16'h0001, 1'b1);
        for (int i = 0; i < 7; i++) tick();
        lit("tenure_last_b", 16'h0001, 1'b0);
        tick();
        lit("expiry_back", 16'h0002, 1'b1);
        reqs_i = 16'h0010;
        tick();
        lit("lone_start", 16'h0010, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        tick();
        lit("lone_expiry", 16'h0010, 1'b1);
        tick();
        lit("lone_after", 16'h0010, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        release_i = 1'b1;
        reqs_i = 16'h0000;
        tick();
        lit("abc_release", 16'h0000, 1'b0);
        tick();
        lit("release_idle", 16'h0000, 1'b0);
        reqs_i = 16'h0004;
        tick();
        lit("release_ignored_idle", 16'h0004, 1'b0);
        release_i = 1'b0;
        tick();
        reset_i = 1'b1;
        tick();
        lit("reset_mid_grant", 16'h0000, 1'b0);
        reset_i = 1'b0;
        tick();
        lit("after_reset", 16'h0004, 1'b0);
        reqs_i = 16'h0000;
        tick();
        lit("final_drop", 16'h0000, 1'b0);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
